// File: rtl/dma_wr_realigner_pkg.sv
// Shared types and constants for the DMA write-path realigner.
// State encodings, default AXI field widths and small elaboration helpers.
package dma_wr_realigner_pkg;

  localparam int AXI_LEN_W_DEF = 8;
  localparam int BOUND_W_DEF   = 12;

  typedef enum logic [1:0] {
    RA_IDLE = 2'd0,
    RA_ADDR = 2'd1,
    RA_DATA = 2'd2,
    RA_DONE = 2'd3
  } ra_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dma_wr_realigner_splitter.sv
// Per-burst beat count: min of beats remaining, AXI max burst and beats left
// before the next 2^BOUND_W byte boundary. Purely combinational on registered inputs.
module dma_burst_splitter
  import dma_wr_realigner_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int AXI_LEN_W = AXI_LEN_W_DEF,
  parameter int CNT_W     = 24,
  parameter int BOUND_W   = BOUND_W_DEF
) (
  input  logic [BOUND_W-1:0]              addr_lo,
  input  logic [CNT_W-$clog2(DATA_W/8):0] remaining,
  output logic [AXI_LEN_W:0]              burst_beats,
  output logic [AXI_LEN_W-1:0]            burst_len
);

  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int RW    = CNT_W - OFF_W + 1;
  localparam int MW    = max_int(max_int(RW, BOUND_W + 1), AXI_LEN_W + 1) + 1;
  localparam logic [MW-1:0] CAP = MW'(2**AXI_LEN_W);

  logic [BOUND_W:0] to_bound;
  logic [MW-1:0]    rem_w, bnd_w;
  logic             use_rem, use_bnd;

  always_comb begin
    to_bound    = (BOUND_W+1)'(2**BOUND_W) - {1'b0, addr_lo};
    rem_w       = MW'(remaining);
    bnd_w       = MW'(to_bound >> OFF_W);
    use_rem     = (rem_w <= CAP) && (rem_w <= bnd_w);
    use_bnd     = !use_rem && (bnd_w <= CAP);
    burst_beats = use_rem ? rem_w[AXI_LEN_W:0] :
                  use_bnd ? bnd_w[AXI_LEN_W:0] : CAP[AXI_LEN_W:0];
    // A full 2^AXI_LEN_W burst wraps the low bits to 0, so minus one still gives the max len.
    burst_len   = burst_beats[AXI_LEN_W-1:0] - 1'b1;
  end

endmodule

// File: rtl/dma_wr_realigner.sv
// Realigns a packed byte stream onto DATA_W-aligned AXI write beats with edge strobes,
// splitting the transfer into boundary-safe bursts with one aw command per burst.
//
// state   | meaning
// RA_IDLE | waiting for run
// RA_ADDR | aw_valid high with current burst addr/len
// RA_DATA | streaming W beats of the current burst
// RA_DONE | one-cycle done pulse
module dma_wr_realigner
  import dma_wr_realigner_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_LEN_W = AXI_LEN_W_DEF,
  parameter int CNT_W     = 24,
  parameter int BOUND_W   = BOUND_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  run,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [CNT_W-1:0]      byte_cnt,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  aw_valid,
  output logic [ADDR_W-1:0]     aw_addr,
  output logic [AXI_LEN_W-1:0]  aw_len,
  input  logic                  aw_ready,
  output logic                  w_valid,
  output logic [DATA_W-1:0]     w_data,
  output logic [DATA_W/8-1:0]   w_strb,
  output logic                  w_last,
  input  logic                  w_ready
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int RW    = CNT_W - OFF_W + 1;
  localparam int SH_W  = OFF_W + 4;

  ra_state_e              state, state_n;
  logic [ADDR_W-1:0]      cur_addr, end_addr;
  logic [RW-1:0]          rem, beats_left, words_left;
  logic [AXI_LEN_W:0]     burst_cnt, burst_beats;
  logic [AXI_LEN_W-1:0]   burst_len;
  logic [DATA_W-1:0]      hold, beat;
  logic [OFF_W-1:0]       off;
  logic [OFF_W:0]         lead;
  logic [SH_W-1:0]        shamt;
  logic [NB-1:0]          first_strb, last_strb, strb;
  logic                   first_beat, need_word, start_xfer;

  dma_burst_splitter #(
    .DATA_W(DATA_W), .AXI_LEN_W(AXI_LEN_W), .CNT_W(CNT_W), .BOUND_W(BOUND_W)
  ) u_splitter (
    .addr_lo     (cur_addr[BOUND_W-1:0]),
    .remaining   (rem),
    .burst_beats (burst_beats),
    .burst_len   (burst_len)
  );

  // Every beat consumes a fresh word while words remain; a trailing beat may need only held bytes.
  always_comb begin
    end_addr   = start_addr + ADDR_W'(byte_cnt) - 1'b1;
    start_xfer = (state == RA_IDLE) && run && (byte_cnt != '0);
    need_word  = (words_left != '0);
    lead       = (OFF_W+1)'(NB) - {1'b0, off};
    shamt      = {lead, 3'b000};
    beat       = DATA_W'({(need_word ? in_data : {DATA_W{1'b0}}), hold} >> shamt);
    strb       = (first_beat ? first_strb : {NB{1'b1}}) &
                 ((beats_left == RW'(1)) ? last_strb : {NB{1'b1}});
  end

  always_comb begin
    state_n  = state;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;
    busy     = 1'b0;
    case (state)
      RA_IDLE: if (run) state_n = (byte_cnt != '0) ? RA_ADDR : RA_DONE;
      RA_ADDR: begin
        busy     = 1'b1;
        aw_valid = 1'b1;
        if (aw_ready) state_n = RA_DATA;
      end
      RA_DATA: begin
        busy     = 1'b1;
        w_valid  = need_word ? in_valid : 1'b1;
        in_ready = need_word & w_ready;
        if (w_valid && w_ready && burst_cnt == (AXI_LEN_W+1)'(1))
          state_n = (rem == '0) ? RA_DONE : RA_ADDR;
      end
      RA_DONE: begin
        done    = 1'b1;
        state_n = RA_IDLE;
      end
      default: state_n = RA_IDLE;
    endcase
  end

  always_comb begin
    aw_addr = aw_valid ? cur_addr : '0;
    aw_len  = aw_valid ? burst_len : '0;
    w_strb  = w_valid ? strb : '0;
    w_last  = w_valid && (burst_cnt == (AXI_LEN_W+1)'(1));
    w_data  = '0;
    for (int j = 0; j < NB; j++)
      w_data[j*8 +: 8] = (w_valid && strb[j]) ? beat[j*8 +: 8] : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RA_IDLE;
      cur_addr   <= '0;
      rem        <= '0;
      beats_left <= '0;
      words_left <= '0;
      burst_cnt  <= '0;
      hold       <= '0;
      off        <= '0;
      first_strb <= '0;
      last_strb  <= '0;
      first_beat <= 1'b0;
    end else if (clear) begin
      state      <= RA_IDLE;
      cur_addr   <= '0;
      rem        <= '0;
      beats_left <= '0;
      words_left <= '0;
      burst_cnt  <= '0;
      hold       <= '0;
      off        <= '0;
      first_strb <= '0;
      last_strb  <= '0;
      first_beat <= 1'b0;
    end else begin
      state <= state_n;
      if (start_xfer) begin
        off        <= start_addr[OFF_W-1:0];
        cur_addr   <= {start_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        rem        <= RW'((end_addr >> OFF_W) - (start_addr >> OFF_W) + 1'b1);
        beats_left <= RW'((end_addr >> OFF_W) - (start_addr >> OFF_W) + 1'b1);
        words_left <= RW'(({1'b0, byte_cnt} + (CNT_W+1)'(NB - 1)) >> OFF_W);
        first_strb <= {NB{1'b1}} << start_addr[OFF_W-1:0];
        last_strb  <= {NB{1'b1}} >> ~end_addr[OFF_W-1:0];
        first_beat <= 1'b1;
        hold       <= '0;
      end
      if (aw_valid && aw_ready) begin
        burst_cnt <= burst_beats;
        rem       <= rem - RW'(burst_beats);
        cur_addr  <= cur_addr + (ADDR_W'(burst_beats) << OFF_W);
      end
      if (w_valid && w_ready) begin
        burst_cnt  <= burst_cnt - 1'b1;
        beats_left <= beats_left - 1'b1;
        first_beat <= 1'b0;
      end
      if (in_valid && in_ready) begin
        hold       <= in_data;
        words_left <= words_left - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_wr_realigner.sv
// Bench for dma_wr_realigner: table of transfers checked through a byte-level scoreboard,
// plus hand sequences for empty transfer, clear mid-burst and a 64-bit instance.
module tb_dma_wr_realigner;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        clear = 0, run = 0, busy, done;
  logic [31:0] start_addr = '0;
  logic [23:0] byte_cnt = '0;
  logic        in_valid = 0, in_ready;
  logic [31:0] in_data = '0;
  logic        aw_valid, aw_ready = 0;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic        w_valid, w_last, w_ready = 0;
  logic [31:0] w_data;
  logic [3:0]  w_strb;

  logic        x_clear = 0, x_run = 0, x_busy, x_done;
  logic [31:0] x_start = '0;
  logic [23:0] x_cnt = '0;
  logic        x_in_valid = 0, x_in_ready;
  logic [63:0] x_in_data = '0;
  logic        x_aw_valid, x_aw_ready = 0;
  logic [31:0] x_aw_addr;
  logic [7:0]  x_aw_len;
  logic        x_w_valid, x_w_last, x_w_ready = 0;
  logic [63:0] x_w_data;
  logic [7:0]  x_w_strb;

  dma_wr_realigner #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .clear(clear), .run(run), .start_addr(start_addr),
    .byte_cnt(byte_cnt), .busy(busy), .done(done), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .aw_valid(aw_valid), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_ready(aw_ready), .w_valid(w_valid), .w_data(w_data),
    .w_strb(w_strb), .w_last(w_last), .w_ready(w_ready));

  dma_wr_realigner #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .clear(x_clear), .run(x_run), .start_addr(x_start),
    .byte_cnt(x_cnt), .busy(x_busy), .done(x_done), .in_valid(x_in_valid),
    .in_data(x_in_data), .in_ready(x_in_ready), .aw_valid(x_aw_valid), .aw_addr(x_aw_addr),
    .aw_len(x_aw_len), .aw_ready(x_aw_ready), .w_valid(x_w_valid), .w_data(x_w_data),
    .w_strb(x_w_strb), .w_last(x_w_last), .w_ready(x_w_ready));

  typedef struct {logic [31:0] addr; logic [7:0] len;} aw_t;
  typedef struct {logic [31:0] data; logic [3:0] strb; logic last;} w_t;
  typedef struct {
    logic [31:0] start; int cnt; bit pat; int pw; int pin; int paw; bit rerun;
    int exp_aw; int exp_beats; int exp_words;
  } vec_t;

  aw_t aw_q[$];
  w_t  w_q[$];
  logic [31:0] words[$];
  vec_t vecs[8];

  int checks = 0, errors = 0;
  int word_idx, n_aw, n_w, n_words, n_done, outstanding, pw, pin, paw;
  bit consumed, sb_en, prev_stall;
  logic [37:0] prev_w;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte-level reference: lane j of beat k carries stream byte k*NB+j-off.
  task automatic build(input logic [31:0] st, input int cnt, input bit pat);
    logic [7:0] b[$];
    w_t beats[$];
    w_t bw;
    aw_t a;
    int off, total, cur, rem, bb, bnd, k, s;
    aw_q.delete(); w_q.delete(); words.delete();
    for (int i = 0; i < cnt; i++) b.push_back(pat ? 8'(8'hA0 + i) : 8'($urandom));
    for (int w = 0; w < (cnt + NB - 1) / NB; w++) begin
      logic [31:0] wd;
      for (int i = 0; i < NB; i++)
        wd[i*8 +: 8] = (w*NB + i < cnt) ? b[w*NB + i] : 8'($urandom);
      words.push_back(wd);
    end
    if (cnt == 0) return;
    off = int'(st) % NB;
    total = (int'(st) + cnt - 1) / NB - int'(st) / NB + 1;
    for (int kk = 0; kk < total; kk++) begin
      bw.data = '0; bw.strb = '0; bw.last = 1'b0;
      for (int j = 0; j < NB; j++) begin
        s = kk*NB + j - off;
        if (s >= 0 && s < cnt) begin
          bw.strb[j] = 1'b1;
          bw.data[j*8 +: 8] = b[s];
        end
      end
      beats.push_back(bw);
    end
    cur = int'(st) - off; rem = total; k = 0;
    while (rem > 0) begin
      bnd = (4096 - cur % 4096) / NB;
      bb = (rem < 256) ? rem : 256;
      if (bnd < bb) bb = bnd;
      a.addr = 32'(cur); a.len = 8'(bb - 1);
      aw_q.push_back(a);
      for (int i = 0; i < bb; i++) begin
        bw = beats[k];
        bw.last = (i == bb - 1);
        w_q.push_back(bw);
        k++;
      end
      cur += bb * NB; rem -= bb;
    end
  endtask

  task automatic step();
    aw_t ea;
    w_t ew;
    @(negedge clk);
    if (consumed) begin word_idx++; consumed = 0; in_valid = 0; end
    if (!in_valid && word_idx < words.size() && $urandom_range(99) < 32'(pin)) begin
      in_valid = 1; in_data = words[word_idx];
    end
    w_ready  = ($urandom_range(99) < 32'(pw));
    aw_ready = ($urandom_range(99) < 32'(paw));
    #1;
    if (sb_en) begin
      if (prev_stall) chk("w_hold", {w_valid, w_last, w_strb, w_data}, prev_w);
      prev_stall = w_valid && !w_ready;
      prev_w = {w_valid, w_last, w_strb, w_data};
      if (aw_valid && aw_ready) begin
        chk("aw_no_pending_w", outstanding, 0);
        if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
        else begin
          ea = aw_q.pop_front();
          chk("aw_addr", aw_addr, ea.addr);
          chk("aw_len", aw_len, ea.len);
        end
        outstanding++; n_aw++;
      end
      if (w_valid && w_ready) begin
        if (w_q.size() == 0) chk("w_unexpected", 1, 0);
        else begin
          ew = w_q.pop_front();
          chk("w_data", w_data, ew.data);
          chk("w_strb", w_strb, ew.strb);
          chk("w_last", w_last, ew.last);
        end
        if (w_last) outstanding--;
        n_w++;
      end
    end
    if (in_valid && in_ready) begin consumed = 1; n_words++; end
    if (done) n_done++;
  endtask

  task automatic reset_counts();
    word_idx = 0; consumed = 0; in_valid = 0; n_aw = 0; n_w = 0; n_words = 0;
    n_done = 0; outstanding = 0; prev_stall = 0;
  endtask

  task automatic run_xfer(input vec_t v);
    build(v.start, v.cnt, v.pat);
    pw = v.pw; pin = v.pin; paw = v.paw; sb_en = 1;
    reset_counts();
    start_addr = v.start; byte_cnt = 24'(v.cnt); run = 1;
    for (int c = 0; c < 20000 && n_done == 0; c++) begin
      if (v.rerun && c == 4) begin run = 1; start_addr = 32'hDEAD0000; byte_cnt = 24'd8; end
      step();
      run = 0;
    end
    repeat (3) step();
    chk("done_count", n_done, 1);
    chk("aw_count", n_aw, v.exp_aw);
    chk("beat_count", n_w, v.exp_beats);
    chk("words_consumed", n_words, v.exp_words);
    chk("aw_left_in_model", aw_q.size(), 0);
    chk("w_left_in_model", w_q.size(), 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    int done_at, x_aw, x_w, x_d, x_words;
    bit x_cons;
    vecs[0] = '{32'h0000_1000,   16, 1, 100, 100, 100, 0, 1,    4,    4};
    vecs[1] = '{32'h0000_1003,    6, 1, 100, 100, 100, 0, 1,    3,    2};
    vecs[2] = '{32'h0000_0FF8,   16, 0, 100, 100, 100, 0, 2,    4,    4};
    vecs[3] = '{32'h0000_0000, 4096, 0,  60,  70,  50, 0, 4, 1024, 1024};
    vecs[4] = '{32'h0000_2001,    1, 0,  80,  80,  80, 0, 1,    1,    1};
    vecs[5] = '{32'h0000_2FFE,    5, 0,  50,  50,  50, 0, 2,    2,    2};
    vecs[6] = '{32'h0000_0F00, 1100, 0,  70,  60,  60, 1, 2,  275,  275};
    vecs[7] = '{32'h0000_3002,    7, 0, 100,  40, 100, 0, 1,    3,    2};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aw_valid", aw_valid, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_w_strb", w_strb, 0);
    chk("rst64_aw_valid", x_aw_valid, 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 8; i++) run_xfer(vecs[i]);

    // Empty transfer: no aw/w, done shortly after run.
    build(32'h100, 0, 0);
    pw = 100; pin = 100; paw = 100; sb_en = 1;
    reset_counts();
    start_addr = 32'h100; byte_cnt = 24'd0; run = 1;
    done_at = -1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) run = 0;
      if (n_done != 0 && done_at < 0) done_at = c;
    end
    chk("zero_done_latency_ok", (done_at >= 1 && done_at <= 2), 1);
    chk("zero_done_count", n_done, 1);
    chk("zero_aw_count", n_aw, 0);
    chk("zero_w_count", n_w, 0);

    // Clear while stalled in DATA: idle next cycle, no done afterwards.
    build(32'h0, 64, 0);
    pw = 0; pin = 100; paw = 100; sb_en = 0;
    reset_counts();
    start_addr = 32'h0; byte_cnt = 24'd64; run = 1;
    step();
    run = 0;
    for (int c = 0; c < 20 && !w_valid; c++) step();
    chk("clr_reached_data", w_valid, 1);
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    #1;
    chk("clr_busy", busy, 0);
    chk("clr_w_valid", w_valid, 0);
    chk("clr_aw_valid", aw_valid, 0);
    chk("clr_in_ready", in_ready, 0);
    n_done = 0;
    pw = 100;
    repeat (6) step();
    chk("clr_no_done", n_done, 0);
    chk("clr_no_aw_after", aw_valid, 0);
    in_valid = 0;

    // 64-bit instance: start 0x5, 3 bytes -> single beat, strobe 0xE0.
    x_aw = 0; x_w = 0; x_d = 0; x_words = 0; x_cons = 0;
    @(negedge clk);
    x_start = 32'h5; x_cnt = 24'd3; x_run = 1;
    x_in_data = 64'h5555_5555_55B2_B1B0; x_in_valid = 1; x_aw_ready = 1; x_w_ready = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      x_run = 0;
      if (x_cons) begin x_in_valid = 0; x_cons = 0; end
      #1;
      if (x_aw_valid && x_aw_ready) begin
        chk("w64_aw_addr", x_aw_addr, 32'h0);
        chk("w64_aw_len", x_aw_len, 8'h0);
        x_aw++;
      end
      if (x_w_valid && x_w_ready) begin
        chk("w64_data", x_w_data, 64'hB2B1_B000_0000_0000);
        chk("w64_strb", x_w_strb, 8'hE0);
        chk("w64_last", x_w_last, 1);
        x_w++;
      end
      if (x_in_valid && x_in_ready) begin x_cons = 1; x_words++; end
      if (x_done) x_d++;
    end
    chk("w64_aw_count", x_aw, 1);
    chk("w64_beat_count", x_w, 1);
    chk("w64_words", x_words, 1);
    chk("w64_done", x_d, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
